// File: rtl/mips_dmem_responder_if.sv
// Data-port bus between the MIPS core (master) and its memory responder (slave).
// Requests are level signals sampled by the responder; completion is a one-cycle mem_ready.
interface mips_dmem_responder_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] memory_data_out;
   logic        mem_ready;
   logic        busy;
   logic        mem_err;
   logic [31:0] err_addr;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   modport master (
      output mem_addr, mem_data_in, mem_read, mem_write,
      input  memory_data_out, mem_ready, busy, mem_err, err_addr, rd_count, wr_count
   );

   modport slave (
      input  mem_addr, mem_data_in, mem_read, mem_write,
      output memory_data_out, mem_ready, busy, mem_err, err_addr, rd_count, wr_count
   );
endinterface

// File: rtl/mips_dmem_responder.sv
// Word-organised data memory for the MIPS core with a fixed wait-state response FSM,
// sticky illegal-access reporting and saturating good-access counters.
module mips_dmem_responder #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   mips_dmem_responder_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;

   logic [31:0] req_addr, req_wdata;
   logic        req_write, req_err;

   logic        accept, acc_err, enter_resp;
   logic [31:0] act_addr, act_wdata;
   logic        act_write, act_err;
   logic [ADDR_W-1:0] act_idx;

   logic [31:0] ram [2**ADDR_W];
   logic [31:0] rdata_r, err_addr_r;
   logic        err_r;
   logic [15:0] rd_cnt_r, wr_cnt_r;

   assign accept  = (state == S_IDLE) && (bus.mem_read || bus.mem_write);
   assign acc_err = (bus.mem_addr[1:0] != 2'b00)
                 || (bus.mem_addr[31:ADDR_W+2] != '0)
                 || (bus.mem_read && bus.mem_write);

   // With no wait states RESP is entered on the acceptance edge itself, before the
   // capture registers load, so the access then uses the live request lines.
   always_comb begin
      if (state == S_IDLE) begin
         act_addr  = bus.mem_addr;
         act_wdata = bus.mem_data_in;
         act_write = bus.mem_write;
         act_err   = acc_err;
      end else begin
         act_addr  = req_addr;
         act_wdata = req_wdata;
         act_write = req_write;
         act_err   = req_err;
      end
   end

   assign act_idx    = act_addr[ADDR_W+1:2];
   assign enter_resp = (state_nxt == S_RESP);

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_RESP;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == 4'd0) state_nxt = S_RESP;
            else                  wait_cnt_nxt = wait_cnt - 4'd1;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_write <= 1'b0;
         req_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            req_addr  <= bus.mem_addr;
            req_wdata <= bus.mem_data_in;
            req_write <= bus.mem_write;
            req_err   <= acc_err;
         end
      end
   end

   // NOTE: the RAM array has no reset so it maps onto memory macros and keeps its contents.
   always_ff @(posedge clk) begin
      if (enter_resp && act_write && !act_err) ram[act_idx] <= act_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r    <= '0;
         err_r      <= 1'b0;
         err_addr_r <= '0;
         rd_cnt_r   <= '0;
         wr_cnt_r   <= '0;
      end else if (enter_resp) begin
         if (act_err) begin
            rdata_r <= '0;
            err_r   <= 1'b1;
            if (!err_r) err_addr_r <= act_addr;
         end else if (act_write) begin
            if (wr_cnt_r != 16'hFFFF) wr_cnt_r <= wr_cnt_r + 16'd1;
         end else begin
            rdata_r <= ram[act_idx];
            if (rd_cnt_r != 16'hFFFF) rd_cnt_r <= rd_cnt_r + 16'd1;
         end
      end
   end

   // mem_ready and busy decode the async-reset state register, so reset drops them at once.
   assign bus.mem_ready       = (state == S_RESP);
   assign bus.busy            = (state != S_IDLE);
   assign bus.memory_data_out = rdata_r;
   assign bus.mem_err         = err_r;
   assign bus.err_addr        = err_addr_r;
   assign bus.rd_count        = rd_cnt_r;
   assign bus.wr_count        = wr_cnt_r;
endmodule
